// File: rtl/gps_multi_chan_gen.sv
// Multi-channel GPS L1 C/A baseband generator: per-channel Gold code, code-phase
// slew and carrier NCO, summed into signed I/Q samples.
module gps_multi_chan_gen #(
    parameter int  N_CH          = 4,
    parameter int  NCO_W         = 16,
    parameter int  CLKS_PER_CHIP = 16,
    localparam int SW            = $clog2(N_CH + 1) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic             ena_in,
    input  logic             cfg_we_in,
    input  logic [2:0]       cfg_ch_in,
    input  logic [3:0]       cfg_tap_a_in,
    input  logic [3:0]       cfg_tap_b_in,
    input  logic [9:0]       cfg_phase_in,
    input  logic [NCO_W-1:0] cfg_fcw_in,
    input  logic             cfg_on_in,
    input  logic [N_CH-1:0]  msg_in,
    output logic [SW-1:0]    i_out,
    output logic [SW-1:0]    q_out,
    output logic [N_CH-1:0]  epoch_out,
    output logic             phase_done_out,
    output logic             cfg_err_out
);
    localparam int                TW        = $clog2(CLKS_PER_CHIP);
    localparam logic [9:0]        LAST_CHIP = 10'd1022;
    localparam logic [9:0]        LFSR_INIT = 10'h3FF;
    localparam logic [TW-1:0]     TICK_LAST = TW'(CLKS_PER_CHIP - 1);
    localparam logic [SW-1:0]     S_ONE     = SW'(1'b1);

    // Stage n of each LFSR lives at bit n-1; output is stage 10.
    function automatic logic [9:0] g1_step(input logic [9:0] g);
        g1_step = {g[8:0], g[2] ^ g[9]};
    endfunction

    function automatic logic [9:0] g2_step(input logic [9:0] g);
        g2_step = {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
    endfunction

    function automatic logic tap_legal(input logic [3:0] t);
        tap_legal = (t >= 4'd1) && (t <= 4'd10);
    endfunction

    function automatic logic tap_sel(input logic [9:0] g, input logic [3:0] t);
        if (tap_legal(t)) begin
            tap_sel = g[t - 4'd1];
        end else begin
            tap_sel = 1'b0;
        end
    endfunction

    logic [9:0]       g1_r       [N_CH];
    logic [9:0]       g2_r       [N_CH];
    logic [9:0]       chip_cnt_r [N_CH];
    logic [9:0]       slew_r     [N_CH];
    logic [3:0]       tap_a_r    [N_CH];
    logic [3:0]       tap_b_r    [N_CH];
    logic [NCO_W-1:0] acc_r      [N_CH];
    logic [NCO_W-1:0] fcw_r      [N_CH];
    logic [N_CH-1:0]  on_r;
    logic [N_CH-1:0]  msg_r;
    logic [TW-1:0]    tick_r;

    logic [SW-1:0]    i_r;
    logic [SW-1:0]    q_r;
    logic [N_CH-1:0]  epoch_r;
    logic             phase_done_r;
    logic             cfg_err_r;

    logic             cfg_ok_s;
    logic             tick_wrap_s;
    logic [N_CH-1:0]  wr_s;
    logic [N_CH-1:0]  slewing_s;
    logic [N_CH-1:0]  adv_s;
    logic [N_CH-1:0]  epoch_hit_s;
    logic             chip_s;
    logic             bit_i_s;
    logic             bit_q_s;
    logic [SW-1:0]    i_sum_s;
    logic [SW-1:0]    q_sum_s;
    logic             any_slew_s;

    // Write decode, per-channel advance/epoch decisions and the I/Q sums
    always_comb begin
        cfg_ok_s    = ({1'b0, cfg_ch_in} < 4'(N_CH)) && tap_legal(cfg_tap_a_in) &&
                      tap_legal(cfg_tap_b_in) && (cfg_phase_in <= LAST_CHIP);
        tick_wrap_s = ena_in && (tick_r == TICK_LAST);
        wr_s        = '0;
        slewing_s   = '0;
        adv_s       = '0;
        epoch_hit_s = '0;
        chip_s      = 1'b0;
        bit_i_s     = 1'b0;
        bit_q_s     = 1'b0;
        i_sum_s     = '0;
        q_sum_s     = '0;
        any_slew_s  = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            wr_s[ch]        = cfg_we_in && cfg_ok_s && (cfg_ch_in == 3'(ch));
            slewing_s[ch]   = (slew_r[ch] != 10'd0);
            adv_s[ch]       = ena_in && on_r[ch] && (slewing_s[ch] || tick_wrap_s);
            // A write to the same channel overrides a coincident epoch.
            epoch_hit_s[ch] = adv_s[ch] && !slewing_s[ch] &&
                              (chip_cnt_r[ch] == LAST_CHIP) && !wr_s[ch];
            chip_s  = g1_r[ch][9] ^ tap_sel(g2_r[ch], tap_a_r[ch]) ^ tap_sel(g2_r[ch], tap_b_r[ch]);
            bit_q_s = chip_s ^ msg_r[ch] ^ acc_r[ch][NCO_W-1];
            bit_i_s = bit_q_s ^ acc_r[ch][NCO_W-2];
            if (on_r[ch] && !slewing_s[ch]) begin
                i_sum_s = bit_i_s ? (i_sum_s - S_ONE) : (i_sum_s + S_ONE);
                q_sum_s = bit_q_s ? (q_sum_s - S_ONE) : (q_sum_s + S_ONE);
            end else begin
                i_sum_s = i_sum_s;
                q_sum_s = q_sum_s;
            end
            any_slew_s = any_slew_s | (on_r[ch] & slewing_s[ch]);
        end
    end

    // Per-channel configuration, code generator, slew and carrier state
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                g1_r[ch]       <= LFSR_INIT;
                g2_r[ch]       <= LFSR_INIT;
                chip_cnt_r[ch] <= 10'd0;
                slew_r[ch]     <= 10'd0;
                tap_a_r[ch]    <= 4'd0;
                tap_b_r[ch]    <= 4'd0;
                acc_r[ch]      <= '0;
                fcw_r[ch]      <= '0;
            end
            on_r  <= '0;
            msg_r <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (wr_s[ch]) begin
                    tap_a_r[ch]    <= cfg_tap_a_in;
                    tap_b_r[ch]    <= cfg_tap_b_in;
                    fcw_r[ch]      <= cfg_fcw_in;
                    on_r[ch]       <= cfg_on_in;
                    g1_r[ch]       <= LFSR_INIT;
                    g2_r[ch]       <= LFSR_INIT;
                    chip_cnt_r[ch] <= 10'd0;
                    acc_r[ch]      <= '0;
                    msg_r[ch]      <= 1'b0;
                    slew_r[ch]     <= cfg_phase_in;
                end else begin
                    if (adv_s[ch]) begin
                        if (chip_cnt_r[ch] == LAST_CHIP) begin
                            g1_r[ch]       <= LFSR_INIT;
                            g2_r[ch]       <= LFSR_INIT;
                            chip_cnt_r[ch] <= 10'd0;
                        end else begin
                            g1_r[ch]       <= g1_step(g1_r[ch]);
                            g2_r[ch]       <= g2_step(g2_r[ch]);
                            chip_cnt_r[ch] <= chip_cnt_r[ch] + 10'd1;
                        end
                        if (slewing_s[ch]) begin
                            slew_r[ch] <= slew_r[ch] - 10'd1;
                        end
                        if (epoch_hit_s[ch]) begin
                            msg_r[ch] <= msg_in[ch];
                        end
                    end
                    if (ena_in && on_r[ch]) begin
                        acc_r[ch] <= acc_r[ch] + fcw_r[ch];
                    end
                end
            end
        end
    end

    // Shared chip-rate tick counter
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            tick_r <= '0;
        end else if (ena_in) begin
            tick_r <= tick_wrap_s ? '0 : (tick_r + TW'(1'b1));
        end
    end

    // Registered outputs: levels hold while disabled, pulses are forced low
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            i_r          <= '0;
            q_r          <= '0;
            epoch_r      <= '0;
            phase_done_r <= 1'b1;
            cfg_err_r    <= 1'b0;
        end else begin
            if (ena_in) begin
                i_r          <= i_sum_s;
                q_r          <= q_sum_s;
                phase_done_r <= !any_slew_s;
                epoch_r      <= epoch_hit_s;
                cfg_err_r    <= cfg_we_in && !cfg_ok_s;
            end else begin
                epoch_r   <= '0;
                cfg_err_r <= 1'b0;
            end
        end
    end

    assign i_out          = i_r;
    assign q_out          = q_r;
    assign epoch_out      = epoch_r;
    assign phase_done_out = phase_done_r;
    assign cfg_err_out    = cfg_err_r;

endmodule
